// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer: allocates indices at dispatch, captures CDB results,
// and retires completed entries in program order, flushing on a mispredicted branch.
module reorder_buffer #(
  parameter int RoB_WIDTH    = 4,
  parameter int RoB_SIZE     = 1 << RoB_WIDTH,
  parameter int EX_REG_WIDTH = 6,
  parameter int NON_REG      = 32
) (
  input  logic                    Sys_clk,
  input  logic                    Sys_rst_n,
  input  logic                    Sys_rdy,
  input  logic                    DPRoB_en,
  input  logic [EX_REG_WIDTH-1:0] DPRoB_rd,
  input  logic                    DPRoB_is_branch,
  input  logic                    DPRoB_pred_taken,
  input  logic [31:0]             DPRoB_alt_pc,
  output logic [RoB_WIDTH-1:0]    RoBDP_index,
  output logic                    RoBDP_full,
  input  logic [RoB_WIDTH-1:0]    DPRoB_Qj,
  input  logic [RoB_WIDTH-1:0]    DPRoB_Qk,
  output logic                    RoBDP_Qj_ready,
  output logic                    RoBDP_Qk_ready,
  output logic [31:0]             RoBDP_Vj,
  output logic [31:0]             RoBDP_Vk,
  input  logic                    CDBRoB_en,
  input  logic [RoB_WIDTH-1:0]    CDBRoB_index,
  input  logic [31:0]             CDBRoB_value,
  input  logic                    CDBRoB_taken,
  output logic                    RoBRF_en,
  output logic [RoB_WIDTH-1:0]    RoBRF_RoB_index,
  output logic [EX_REG_WIDTH-1:0] RoBRF_rd,
  output logic [31:0]             RoBRF_value,
  output logic                    RoBRF_pre_judge,
  output logic                    RoBIF_jump_en,
  output logic [31:0]             RoBIF_pc
);

  logic [RoB_WIDTH-1:0]    head, tail;
  logic [RoB_WIDTH:0]      count;
  logic [RoB_SIZE-1:0]     valid, ready, is_branch, pred_taken, taken;
  logic [EX_REG_WIDTH-1:0] rd     [RoB_SIZE];
  logic [31:0]             value  [RoB_SIZE];
  logic [31:0]             alt_pc [RoB_SIZE];

  logic full, commit, flush, alloc, cdb_wr, retire;

  assign full   = (count == (RoB_WIDTH+1)'(RoB_SIZE));
  assign commit = Sys_rdy && valid[head] && ready[head];
  assign flush  = commit && is_branch[head] && (taken[head] != pred_taken[head]);
  assign retire = commit && !flush;
  // A flush discards anything else that would have landed in the same cycle.
  assign alloc  = DPRoB_en && !full && Sys_rdy && !flush;
  assign cdb_wr = CDBRoB_en && Sys_rdy && !flush && valid[CDBRoB_index];

  assign RoBDP_full      = full;
  assign RoBDP_index     = tail;
  assign RoBRF_en        = commit;
  assign RoBRF_RoB_index = head;
  assign RoBRF_rd        = rd[head];
  assign RoBRF_value     = value[head];
  assign RoBRF_pre_judge = !flush;
  assign RoBIF_jump_en   = flush;
  assign RoBIF_pc        = alt_pc[head];

  always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
    if (!Sys_rst_n) begin
      valid <= '0;
      ready <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < RoB_SIZE; i++) rd[i] <= EX_REG_WIDTH'(NON_REG);
    end else if (flush) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (cdb_wr) ready[CDBRoB_index] <= 1'b1;
      // Allocation never targets the head while it is retiring: not-full implies tail != head.
      if (alloc) begin
        valid[tail] <= 1'b1;
        ready[tail] <= 1'b0;
        rd[tail]    <= DPRoB_rd;
        tail        <= tail + 1'b1;
      end
      if (retire) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      if (alloc && !retire)      count <= count + 1'b1;
      else if (!alloc && retire) count <= count - 1'b1;
    end
  end

  // Payload fields need no reset; valid/ready gate every use of them.
  always_ff @(posedge Sys_clk) begin
    if (alloc) begin
      is_branch[tail]  <= DPRoB_is_branch;
      pred_taken[tail] <= DPRoB_pred_taken;
      alt_pc[tail]     <= DPRoB_alt_pc;
    end
    if (cdb_wr) begin
      value[CDBRoB_index] <= CDBRoB_value;
      taken[CDBRoB_index] <= CDBRoB_taken;
    end
  end

  always_comb begin
    RoBDP_Qj_ready = 1'b0;
    RoBDP_Vj       = '0;
    if (CDBRoB_en && CDBRoB_index == DPRoB_Qj && valid[DPRoB_Qj]) begin
      RoBDP_Qj_ready = 1'b1;
      RoBDP_Vj       = CDBRoB_value;
    end else if (valid[DPRoB_Qj] && ready[DPRoB_Qj]) begin
      RoBDP_Qj_ready = 1'b1;
      RoBDP_Vj       = value[DPRoB_Qj];
    end
  end

  always_comb begin
    RoBDP_Qk_ready = 1'b0;
    RoBDP_Vk       = '0;
    if (CDBRoB_en && CDBRoB_index == DPRoB_Qk && valid[DPRoB_Qk]) begin
      RoBDP_Qk_ready = 1'b1;
      RoBDP_Vk       = CDBRoB_value;
    end else if (valid[DPRoB_Qk] && ready[DPRoB_Qk]) begin
      RoBDP_Qk_ready = 1'b1;
      RoBDP_Vk       = value[DPRoB_Qk];
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: allocation, fill/wrap, commit,
// mispredict flush, operand lookup forwarding, Sys_rdy stall and async reset.
module tb_reorder_buffer;

  logic        Sys_clk = 1'b0;
  logic        Sys_rst_n;
  logic        Sys_rdy;
  logic        DPRoB_en;
  logic [5:0]  DPRoB_rd;
  logic        DPRoB_is_branch;
  logic        DPRoB_pred_taken;
  logic [31:0] DPRoB_alt_pc;
  logic [3:0]  RoBDP_index;
  logic        RoBDP_full;
  logic [3:0]  DPRoB_Qj, DPRoB_Qk;
  logic        RoBDP_Qj_ready, RoBDP_Qk_ready;
  logic [31:0] RoBDP_Vj, RoBDP_Vk;
  logic        CDBRoB_en;
  logic [3:0]  CDBRoB_index;
  logic [31:0] CDBRoB_value;
  logic        CDBRoB_taken;
  logic        RoBRF_en;
  logic [3:0]  RoBRF_RoB_index;
  logic [5:0]  RoBRF_rd;
  logic [31:0] RoBRF_value;
  logic        RoBRF_pre_judge;
  logic        RoBIF_jump_en;
  logic [31:0] RoBIF_pc;

  int total = 0;
  int bad   = 0;

  reorder_buffer dut (
    .Sys_clk(Sys_clk), .Sys_rst_n(Sys_rst_n), .Sys_rdy(Sys_rdy),
    .DPRoB_en(DPRoB_en), .DPRoB_rd(DPRoB_rd), .DPRoB_is_branch(DPRoB_is_branch),
    .DPRoB_pred_taken(DPRoB_pred_taken), .DPRoB_alt_pc(DPRoB_alt_pc),
    .RoBDP_index(RoBDP_index), .RoBDP_full(RoBDP_full),
    .DPRoB_Qj(DPRoB_Qj), .DPRoB_Qk(DPRoB_Qk),
    .RoBDP_Qj_ready(RoBDP_Qj_ready), .RoBDP_Qk_ready(RoBDP_Qk_ready),
    .RoBDP_Vj(RoBDP_Vj), .RoBDP_Vk(RoBDP_Vk),
    .CDBRoB_en(CDBRoB_en), .CDBRoB_index(CDBRoB_index),
    .CDBRoB_value(CDBRoB_value), .CDBRoB_taken(CDBRoB_taken),
    .RoBRF_en(RoBRF_en), .RoBRF_RoB_index(RoBRF_RoB_index), .RoBRF_rd(RoBRF_rd),
    .RoBRF_value(RoBRF_value), .RoBRF_pre_judge(RoBRF_pre_judge),
    .RoBIF_jump_en(RoBIF_jump_en), .RoBIF_pc(RoBIF_pc)
  );

  always #5 Sys_clk = ~Sys_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic dp_en, input logic [5:0] rd, input logic br,
                               input logic pred, input logic [31:0] alt,
                               input logic cdb_en, input logic [3:0] cdb_idx,
                               input logic [31:0] cdb_val, input logic cdb_taken);
    DPRoB_en         = dp_en;
    DPRoB_rd         = rd;
    DPRoB_is_branch  = br;
    DPRoB_pred_taken = pred;
    DPRoB_alt_pc     = alt;
    CDBRoB_en        = cdb_en;
    CDBRoB_index     = cdb_idx;
    CDBRoB_value     = cdb_val;
    CDBRoB_taken     = cdb_taken;
    #1;
  endtask

  // Inputs change 1ns after the rising edge; checks follow another 1ns of settling.
  task automatic stepClock();
    @(posedge Sys_clk);
    #1;
  endtask

  initial begin
    Sys_rst_n = 1'b0;
    Sys_rdy   = 1'b1;
    DPRoB_Qj  = 4'd0;
    DPRoB_Qk  = 4'd0;
    applyStimulus(0, 6'd0, 0, 0, 32'h0, 0, 4'd0, 32'h0, 0);

    // Reset state
    checkOutput("rst_en", RoBRF_en, 0);
    checkOutput("rst_pre_judge", RoBRF_pre_judge, 1);
    checkOutput("rst_jump", RoBIF_jump_en, 0);
    checkOutput("rst_full", RoBDP_full, 0);
    checkOutput("rst_index", RoBDP_index, 0);
    checkOutput("rst_qj_ready", RoBDP_Qj_ready, 0);
    stepClock();
    Sys_rst_n = 1'b1;
    stepClock();

    // Fill all 16 entries, rd = slot number
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 6'(i), 0, 0, 32'h0, 0, 4'd0, 32'h0, 0);
      stepClock();
    end
    applyStimulus(1, 6'd20, 0, 0, 32'h0, 0, 4'd0, 32'h0, 0);
    checkOutput("fill_full", RoBDP_full, 1);
    checkOutput("fill_index_wrap", RoBDP_index, 0);
    stepClock();
    checkOutput("drop17_full", RoBDP_full, 1);
    checkOutput("drop17_index", RoBDP_index, 0);

    // Complete entry 0, then try allocating while committing at full
    applyStimulus(0, 6'd0, 0, 0, 32'h0, 1, 4'd0, 32'hAA, 0);
    checkOutput("cdb_head_no_commit", RoBRF_en, 0);
    stepClock();
    applyStimulus(1, 6'd21, 0, 0, 32'h0, 0, 4'd0, 32'h0, 0);
    checkOutput("full_commit_en", RoBRF_en, 1);
    checkOutput("full_commit_rd", RoBRF_rd, 0);
    checkOutput("full_commit_val", RoBRF_value, 32'hAA);
    checkOutput("full_commit_idx", RoBRF_RoB_index, 0);
    checkOutput("full_commit_full", RoBDP_full, 1);
    stepClock();
    checkOutput("after_commit_full", RoBDP_full, 0);
    checkOutput("after_commit_index", RoBDP_index, 0);
    checkOutput("after_commit_head", RoBRF_RoB_index, 1);
    applyStimulus(1, 6'd22, 0, 0, 32'h0, 0, 4'd0, 32'h0, 0);
    stepClock();
    checkOutput("realloc_index", RoBDP_index, 1);
    checkOutput("realloc_full", RoBDP_full, 1);

    // Make head ready, then reset asynchronously mid-cycle
    applyStimulus(0, 6'd0, 0, 0, 32'h0, 1, 4'd1, 32'h5, 0);
    stepClock();
    applyStimulus(0, 6'd0, 0, 0, 32'h0, 0, 4'd0, 32'h0, 0);
    checkOutput("prerst_en", RoBRF_en, 1);
    #2 Sys_rst_n = 1'b0;
    #1;
    checkOutput("midrst_en", RoBRF_en, 0);
    checkOutput("midrst_full", RoBDP_full, 0);
    checkOutput("midrst_index", RoBDP_index, 0);
    checkOutput("midrst_pre_judge", RoBRF_pre_judge, 1);
    #2 Sys_rst_n = 1'b1;
    stepClock();
    checkOutput("postrst_index", RoBDP_index, 0);

    // Simple allocate -> writeback -> commit
    applyStimulus(1, 6'd3, 0, 0, 32'h0, 0, 4'd0, 32'h0, 0);
    checkOutput("basic_alloc_index", RoBDP_index, 0);
    stepClock();
    DPRoB_Qj = 4'd0;
    applyStimulus(0, 6'd0, 0, 0, 32'h0, 1, 4'd0, 32'h1234, 0);
    checkOutput("basic_no_early_commit", RoBRF_en, 0);
    checkOutput("basic_fwd_ready", RoBDP_Qj_ready, 1);
    checkOutput("basic_fwd_val", RoBDP_Vj, 32'h1234);
    stepClock();
    applyStimulus(0, 6'd0, 0, 0, 32'h0, 0, 4'd0, 32'h0, 0);
    checkOutput("basic_en", RoBRF_en, 1);
    checkOutput("basic_rd", RoBRF_rd, 3);
    checkOutput("basic_val", RoBRF_value, 32'h1234);
    checkOutput("basic_pre_judge", RoBRF_pre_judge, 1);
    checkOutput("basic_idx", RoBRF_RoB_index, 0);
    stepClock();
    checkOutput("basic_done_en", RoBRF_en, 0);
    checkOutput("basic_done_index", RoBDP_index, 1);

    // Mispredicted branch at index 1 with three younger entries
    applyStimulus(1, 6'd32, 1, 1, 32'h100, 0, 4'd0, 32'h0, 0);
    stepClock();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 6'(7 + i), 0, 0, 32'h0, 0, 4'd0, 32'h0, 0);
      stepClock();
    end
    applyStimulus(0, 6'd0, 0, 0, 32'h0, 1, 4'd1, 32'h0, 0);
    stepClock();
    applyStimulus(1, 6'd13, 0, 0, 32'h0, 1, 4'd2, 32'h9, 0);
    checkOutput("mis_en", RoBRF_en, 1);
    checkOutput("mis_pre_judge", RoBRF_pre_judge, 0);
    checkOutput("mis_jump", RoBIF_jump_en, 1);
    checkOutput("mis_pc", RoBIF_pc, 32'h100);
    checkOutput("mis_idx", RoBRF_RoB_index, 1);
    stepClock();
    DPRoB_Qj = 4'd2;
    applyStimulus(0, 6'd0, 0, 0, 32'h0, 0, 4'd0, 32'h0, 0);
    checkOutput("flush_index", RoBDP_index, 0);
    checkOutput("flush_en", RoBRF_en, 0);
    checkOutput("flush_jump", RoBIF_jump_en, 0);
    checkOutput("flush_qj_ready", RoBDP_Qj_ready, 0);
    checkOutput("flush_head", RoBRF_RoB_index, 0);

    // Lookup forwarding: entries 0..2 rd 10..12
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 6'(10 + i), 0, 0, 32'h0, 0, 4'd0, 32'h0, 0);
      stepClock();
    end
    DPRoB_Qj = 4'd2;
    DPRoB_Qk = 4'd1;
    applyStimulus(0, 6'd0, 0, 0, 32'h0, 1, 4'd2, 32'h7, 0);
    checkOutput("lk_fwd_ready", RoBDP_Qj_ready, 1);
    checkOutput("lk_fwd_val", RoBDP_Vj, 7);
    checkOutput("lk_pend_ready", RoBDP_Qk_ready, 0);
    checkOutput("lk_pend_val", RoBDP_Vk, 0);
    stepClock();
    DPRoB_Qk = 4'd3;
    applyStimulus(0, 6'd0, 0, 0, 32'h0, 1, 4'd3, 32'h99, 0);
    checkOutput("lk_stored_ready", RoBDP_Qj_ready, 1);
    checkOutput("lk_stored_val", RoBDP_Vj, 7);
    checkOutput("lk_invalid_ready", RoBDP_Qk_ready, 0);
    checkOutput("lk_invalid_val", RoBDP_Vk, 0);
    stepClock();

    // Sys_rdy stall with a ready head
    applyStimulus(0, 6'd0, 0, 0, 32'h0, 1, 4'd0, 32'h55, 0);
    stepClock();
    Sys_rdy = 1'b0;
    applyStimulus(1, 6'd14, 0, 0, 32'h0, 0, 4'd0, 32'h0, 0);
    checkOutput("stall_en", RoBRF_en, 0);
    checkOutput("stall_pre_judge", RoBRF_pre_judge, 1);
    stepClock();
    checkOutput("stall_en_hold", RoBRF_en, 0);
    checkOutput("stall_head", RoBRF_RoB_index, 0);
    checkOutput("stall_no_alloc", RoBDP_index, 3);
    Sys_rdy = 1'b1;
    applyStimulus(0, 6'd0, 0, 0, 32'h0, 0, 4'd0, 32'h0, 0);
    checkOutput("resume_en", RoBRF_en, 1);
    checkOutput("resume_rd", RoBRF_rd, 10);
    checkOutput("resume_val", RoBRF_value, 32'h55);
    stepClock();
    checkOutput("resume_head", RoBRF_RoB_index, 1);
    checkOutput("resume_next_en", RoBRF_en, 0);
    checkOutput("resume_index", RoBDP_index, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
